// File: rtl/uart_bus_pkg.sv
// Shared types and byte codes for the UART-to-bus debug bridge.
package uart_bus_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      WDATA    = 3'd2,
      BUS_REQ  = 3'd3,
      BUS_WAIT = 3'd4,
      RESP     = 3'd5
   } state_e;

   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_OK    = 8'h4B;
   localparam logic [7:0] RSP_ERR   = 8'h45;
   localparam logic [7:0] RSP_TO    = 8'h54;

endpackage

// File: rtl/bus_if.sv
// Single-word request/response bus between an initiator and a target.
interface bus_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;

   modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
   modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/uart_bus_master_phy.sv
// Serial line building blocks: input synchronizer, 8N1 receiver and 8N1 transmitter.
module synchronizer #(
   parameter int unsigned STAGES      = 3,
   parameter logic        RESET_VALUE = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_r;

   // Shift register clocking the asynchronous input into clk_i
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_r <= {STAGES{RESET_VALUE}};
      end else begin
         sync_r <= {sync_r[STAGES-2:0], d};
      end
   end

   assign q = sync_r[STAGES-1];
endmodule

module uart_rx (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] wait_cycles,
   input  logic        rx,
   output logic [7:0]  data,
   output logic        valid
);
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_e;

   rx_state_e   state_r;
   logic [15:0] cnt_r;
   logic [2:0]  bit_r;
   logic [7:0]  shift_r;
   logic [7:0]  data_r;
   logic        valid_r;

   // Mid-bit sampling receiver; valid stays high until the next start bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= RX_IDLE;
         cnt_r   <= 16'd0;
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         data_r  <= 8'd0;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            RX_IDLE: begin
               if (!rx) begin
                  valid_r <= 1'b0;
                  cnt_r   <= (wait_cycles >> 1) - 16'd1;
                  state_r <= RX_START;
               end
            end
            RX_START: begin
               if (cnt_r != 16'd0) begin
                  cnt_r <= cnt_r - 16'd1;
               end else if (!rx) begin
                  cnt_r   <= wait_cycles - 16'd1;
                  bit_r   <= 3'd0;
                  state_r <= RX_DATA;
               end else begin
                  state_r <= RX_IDLE;
               end
            end
            RX_DATA: begin
               if (cnt_r != 16'd0) begin
                  cnt_r <= cnt_r - 16'd1;
               end else begin
                  shift_r <= {rx, shift_r[7:1]};
                  cnt_r   <= wait_cycles - 16'd1;
                  bit_r   <= bit_r + 3'd1;
                  if (bit_r == 3'd7) begin
                     state_r <= RX_STOP;
                  end
               end
            end
            RX_STOP: begin
               if (cnt_r != 16'd0) begin
                  cnt_r <= cnt_r - 16'd1;
               end else begin
                  if (rx) begin
                     data_r  <= shift_r;
                     valid_r <= 1'b1;
                  end
                  state_r <= RX_IDLE;
               end
            end
            default: state_r <= RX_IDLE;
         endcase
      end
   end

   assign data  = data_r;
   assign valid = valid_r;
endmodule

module uart_tx (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] wait_cycles,
   input  logic        start,
   input  logic [7:0]  data,
   output logic        tx,
   output logic        busy
);
   logic [8:0]  shift_r;
   logic [15:0] cnt_r;
   logic [3:0]  bit_r;
   logic        tx_r;
   logic        busy_r;

   // Start bit, 8 data bits LSB first, stop bit; busy covers the whole stop bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_r <= 9'd0;
         cnt_r   <= 16'd0;
         bit_r   <= 4'd0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else if (!busy_r) begin
         if (start) begin
            shift_r <= {1'b1, data};
            cnt_r   <= 16'd0;
            bit_r   <= 4'd0;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
         end
      end else if (cnt_r == wait_cycles - 16'd1) begin
         cnt_r <= 16'd0;
         if (bit_r == 4'd9) begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
         end else begin
            tx_r    <= shift_r[0];
            shift_r <= {1'b1, shift_r[8:1]};
            bit_r   <= bit_r + 4'd1;
         end
      end else begin
         cnt_r <= cnt_r + 16'd1;
      end
   end

   assign tx   = tx_r;
   assign busy = busy_r;
endmodule

// File: rtl/uart_bus_master.sv
// UART-to-bus debug bridge: serial command frames become single-word bus
// transactions and the result is returned on the same serial link.
module uart_bus_master
   import uart_bus_pkg::*;
#(
   parameter int unsigned FREQUENCY      = 40_000_000,
   parameter int unsigned BAUDRATE       = 9600,
   parameter int unsigned TIMEOUT_CYCLES = 4 * (FREQUENCY / BAUDRATE) * 10,
   parameter int unsigned BUS_TIMEOUT    = 1024
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   bus_if.master bus,
   input  logic  uart_rx,
   output logic  uart_tx,
   output logic  busy_o
);
   localparam logic [15:0]       WAIT_CYCLES = 16'(FREQUENCY / BAUDRATE);
   localparam int unsigned       GAP_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned       BTM_W       = $clog2(BUS_TIMEOUT + 1);
   localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BTM_W-1:0]  BTM_LAST    = BTM_W'(BUS_TIMEOUT - 1);

   logic             rx_sync_s;
   logic [7:0]       rx_data_s;
   logic             rx_valid_s;
   logic             rx_valid_q_r;
   logic             strobe_s;
   logic             tx_busy_s;

   state_e           state_r;
   logic [1:0]       cnt_r;
   logic [GAP_W-1:0] gap_r;
   logic [BTM_W-1:0] btm_r;
   logic             req_r;
   logic             we_r;
   logic [3:0]       be_r;
   logic [31:0]      addr_r;
   logic [31:0]      wdata_r;
   logic             busy_r;
   logic [31:0]      rsp_data_r;
   logic [2:0]       rsp_left_r;
   logic             tx_arm_r;
   logic             tx_start_r;
   logic [7:0]       tx_data_r;

   synchronizer #(.STAGES(3), .RESET_VALUE(1'b1)) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d     (uart_rx),
      .q     (rx_sync_s)
   );

   uart_rx u_rx (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wait_cycles(WAIT_CYCLES),
      .rx         (rx_sync_s),
      .data       (rx_data_s),
      .valid      (rx_valid_s)
   );

   uart_tx u_tx (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wait_cycles(WAIT_CYCLES),
      .start      (tx_start_r),
      .data       (tx_data_r),
      .tx         (uart_tx),
      .busy       (tx_busy_s)
   );

   // Delayed receiver valid for rising-edge byte strobe detection
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_valid_q_r <= 1'b0;
      end else begin
         rx_valid_q_r <= rx_valid_s;
      end
   end

   assign strobe_s = rx_valid_s & ~rx_valid_q_r;

   // Frame parser, bus sequencer, gap/bus timers and response sender
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r    <= IDLE;
         cnt_r      <= 2'd0;
         gap_r      <= {GAP_W{1'b0}};
         btm_r      <= {BTM_W{1'b0}};
         req_r      <= 1'b0;
         we_r       <= 1'b0;
         be_r       <= 4'h0;
         addr_r     <= 32'h0;
         wdata_r    <= 32'h0;
         busy_r     <= 1'b0;
         rsp_data_r <= 32'h0;
         rsp_left_r <= 3'd0;
         tx_arm_r   <= 1'b0;
         tx_start_r <= 1'b0;
         tx_data_r  <= 8'h0;
      end else begin
         tx_start_r <= 1'b0;
         case (state_r)
            IDLE: begin
               gap_r <= {GAP_W{1'b0}};
               if (strobe_s && (rx_data_s == CMD_WRITE || rx_data_s == CMD_READ)) begin
                  we_r    <= (rx_data_s == CMD_WRITE);
                  cnt_r   <= 2'd0;
                  busy_r  <= 1'b1;
                  state_r <= ADDR;
               end
            end
            ADDR, WDATA: begin
               if (strobe_s) begin
                  gap_r <= {GAP_W{1'b0}};
                  cnt_r <= cnt_r + 2'd1;
                  if (state_r == ADDR) begin
                     addr_r[{cnt_r, 3'b000} +: 8] <= rx_data_s;
                  end else begin
                     wdata_r[{cnt_r, 3'b000} +: 8] <= rx_data_s;
                  end
                  if (cnt_r == 2'd3) begin
                     if (state_r == ADDR && we_r) begin
                        state_r <= WDATA;
                     end else begin
                        // Word-aligned access; low address bits are not transmitted on the bus
                        addr_r[1:0] <= 2'b00;
                        req_r       <= 1'b1;
                        be_r        <= 4'hF;
                        btm_r       <= {BTM_W{1'b0}};
                        state_r     <= BUS_REQ;
                     end
                  end
               end else if (gap_r == GAP_LAST) begin
                  gap_r   <= {GAP_W{1'b0}};
                  cnt_r   <= 2'd0;
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  gap_r <= gap_r + GAP_W'(1);
               end
            end
            BUS_REQ: begin
               btm_r <= btm_r + BTM_W'(1);
               if (req_r && bus.gnt) begin
                  req_r   <= 1'b0;
                  be_r    <= 4'h0;
                  state_r <= BUS_WAIT;
               end else if (btm_r == BTM_LAST) begin
                  req_r      <= 1'b0;
                  be_r       <= 4'h0;
                  rsp_data_r <= {24'h0, RSP_TO};
                  rsp_left_r <= 3'd1;
                  tx_arm_r   <= 1'b0;
                  state_r    <= RESP;
               end
            end
            BUS_WAIT: begin
               btm_r <= btm_r + BTM_W'(1);
               if (bus.rvalid) begin
                  if (bus.err) begin
                     rsp_data_r <= {24'h0, RSP_ERR};
                     rsp_left_r <= 3'd1;
                  end else if (we_r) begin
                     rsp_data_r <= {24'h0, RSP_OK};
                     rsp_left_r <= 3'd1;
                  end else begin
                     rsp_data_r <= bus.rdata;
                     rsp_left_r <= 3'd4;
                  end
                  tx_arm_r <= 1'b0;
                  state_r  <= RESP;
               end else if (btm_r == BTM_LAST) begin
                  rsp_data_r <= {24'h0, RSP_TO};
                  rsp_left_r <= 3'd1;
                  tx_arm_r   <= 1'b0;
                  state_r    <= RESP;
               end
            end
            RESP: begin
               // The arm cycle lets the transmitter's busy flag rise before it is sampled
               if (tx_arm_r) begin
                  tx_arm_r <= 1'b0;
               end else if (!tx_busy_s) begin
                  if (rsp_left_r == 3'd0) begin
                     busy_r  <= 1'b0;
                     state_r <= IDLE;
                  end else begin
                     tx_start_r <= 1'b1;
                     tx_data_r  <= rsp_data_r[7:0];
                     rsp_data_r <= {8'h0, rsp_data_r[31:8]};
                     rsp_left_r <= rsp_left_r - 3'd1;
                     tx_arm_r   <= 1'b1;
                  end
               end
            end
            default: begin
               req_r   <= 1'b0;
               be_r    <= 4'h0;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.req   = req_r;
   assign bus.we    = we_r;
   assign bus.be    = be_r;
   assign bus.addr  = addr_r;
   assign bus.wdata = wdata_r;
   assign busy_o    = busy_r;
endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: serial frames in, bus slave model, serial responses decoded.
module tb_uart_bus_master;
   localparam int BITC = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_line;
   logic uart_tx;
   logic busy_o;
   int   checks = 0;
   int   errors = 0;

   bus_if bus ();

   uart_bus_master #(.FREQUENCY(160), .BAUDRATE(10), .BUS_TIMEOUT(1024)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus),
      .uart_rx(rx_line),
      .uart_tx(uart_tx),
      .busy_o (busy_o)
   );

   always #5 clk = ~clk;

   // Slave configuration, written by the stimulus
   logic        gnt_en    = 1'b1;
   int          gnt_delay = 0;
   int          rv_delay  = 1;
   logic [31:0] cfg_rdata = 32'h0;
   logic        cfg_err   = 1'b0;

   // Slave state and cumulative statistics
   int          req_cnt = 0;
   int          rv_cnt  = 0;
   logic        pend    = 1'b0;
   int          grants = 0, req_cycles = 0, req_changes = 0;
   logic [31:0] g_addr = 32'h0, g_wdata = 32'h0, p_addr = 32'h0, p_wdata = 32'h0;
   logic [3:0]  g_be = 4'h0;
   logic        g_we = 1'b0, p_we = 1'b0;

   assign bus.gnt    = bus.req && gnt_en && (req_cnt == gnt_delay);
   assign bus.rvalid = pend && (rv_cnt >= rv_delay);
   assign bus.rdata  = bus.rvalid ? cfg_rdata : 32'h0;
   assign bus.err    = bus.rvalid & cfg_err;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_cnt <= 0;
         rv_cnt  <= 0;
         pend    <= 1'b0;
      end else begin
         if (bus.req) begin
            req_cnt    <= req_cnt + 1;
            req_cycles <= req_cycles + 1;
            if (req_cnt > 0 && (bus.addr != p_addr || bus.we != p_we || bus.wdata != p_wdata))
               req_changes <= req_changes + 1;
            p_addr  <= bus.addr;
            p_we    <= bus.we;
            p_wdata <= bus.wdata;
         end else begin
            req_cnt <= 0;
         end
         if (bus.req && bus.gnt) begin
            grants  <= grants + 1;
            g_addr  <= bus.addr;
            g_wdata <= bus.wdata;
            g_be    <= bus.be;
            g_we    <= bus.we;
            pend    <= 1'b1;
            rv_cnt  <= 1;
         end else if (pend) begin
            if (bus.rvalid) pend <= 1'b0;
            else rv_cnt <= rv_cnt + 1;
         end
      end
   end

   // Serial response decoder
   logic [7:0] tx_q[$];
   logic       mon_act = 1'b0;
   int         mon_cnt = 0;
   int         mon_bit = 0;
   logic [7:0] mon_sh  = 8'h00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mon_act <= 1'b0;
         mon_cnt <= 0;
         mon_bit <= 0;
      end else if (!mon_act) begin
         if (uart_tx === 1'b0) begin
            mon_act <= 1'b1;
            mon_cnt <= 0;
            mon_bit <= 0;
         end
      end else begin
         mon_cnt <= mon_cnt + 1;
         if (mon_bit < 8 && mon_cnt == 24 + BITC * mon_bit) begin
            mon_sh[mon_bit] <= uart_tx;
            mon_bit <= mon_bit + 1;
         end else if (mon_bit == 8 && mon_cnt == 152) begin
            tx_q.push_back(mon_sh);
            mon_act <= 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tx_at(input int idx);
      if (idx < tx_q.size()) return 32'(tx_q[idx]);
      else return 32'hFFFF_FFFF;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      rx_line = 1'b0;
      repeat (BITC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_line = b[i];
         repeat (BITC) @(negedge clk);
      end
      rx_line = 1'b1;
      repeat (BITC) @(negedge clk);
   endtask

   task automatic send_frame(input logic [71:0] frame, input int n);
      for (int i = 0; i < n; i++) send_byte(frame[8*i +: 8]);
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while (busy_o !== 1'b0 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(busy_o), 32'd0);
   endtask

   int n0, g0, r0, c0, k;

   initial begin
      rst_n   = 1'b0;
      rx_line = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req",   32'(bus.req),   32'd0);
      chk("rst_we",    32'(bus.we),    32'd0);
      chk("rst_be",    32'(bus.be),    32'd0);
      chk("rst_addr",  bus.addr,       32'd0);
      chk("rst_wdata", bus.wdata,      32'd0);
      chk("rst_tx",    32'(uart_tx),   32'd1);
      chk("rst_busy",  32'(busy_o),    32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Plain write
      n0 = tx_q.size(); g0 = grants;
      send_byte(8'h57);
      chk("wr_busy_cmd", 32'(busy_o), 32'd1);
      send_frame(72'h00_DE_AD_BE_EF_20_00_00_00, 8);
      wait_idle("wr", 3000);
      chk("wr_grants", 32'(grants - g0), 32'd1);
      chk("wr_addr",   g_addr,  32'h2000_0000);
      chk("wr_wdata",  g_wdata, 32'hDEAD_BEEF);
      chk("wr_be",     32'(g_be), 32'hF);
      chk("wr_we",     32'(g_we), 32'd1);
      chk("wr_txn",    32'(tx_q.size() - n0), 32'd1);
      chk("wr_tx0",    tx_at(n0), 32'h4B);

      // Plain read
      cfg_rdata = 32'h1234_5678; rv_delay = 3;
      n0 = tx_q.size(); g0 = grants;
      send_frame(72'h00_00_00_00_10_04_52, 5);
      wait_idle("rd", 3000);
      chk("rd_grants", 32'(grants - g0), 32'd1);
      chk("rd_addr",   g_addr, 32'h0000_1004);
      chk("rd_we",     32'(g_we), 32'd0);
      chk("rd_txn",    32'(tx_q.size() - n0), 32'd4);
      chk("rd_tx0",    tx_at(n0),     32'h78);
      chk("rd_tx1",    tx_at(n0 + 1), 32'h56);
      chk("rd_tx2",    tx_at(n0 + 2), 32'h34);
      chk("rd_tx3",    tx_at(n0 + 3), 32'h12);

      // Read with grant held off for 7 cycles
      gnt_delay = 7;
      n0 = tx_q.size(); g0 = grants; r0 = req_cycles; c0 = req_changes;
      send_frame(72'h00_00_00_00_10_04_52, 5);
      wait_idle("gd", 3000);
      chk("gd_req_cycles", 32'(req_cycles - r0), 32'd8);
      chk("gd_changes",    32'(req_changes - c0), 32'd0);
      chk("gd_grants",     32'(grants - g0), 32'd1);
      chk("gd_addr",       g_addr, 32'h0000_1004);
      chk("gd_tx0",        tx_at(n0),     32'h78);
      chk("gd_tx3",        tx_at(n0 + 3), 32'h12);
      gnt_delay = 0;

      // Write answered with a bus error
      cfg_err = 1'b1;
      n0 = tx_q.size(); g0 = grants;
      send_frame(72'h11_22_33_44_00_00_00_40_57, 9);
      wait_idle("er", 3000);
      chk("er_grants", 32'(grants - g0), 32'd1);
      chk("er_wdata",  g_wdata, 32'h1122_3344);
      chk("er_txn",    32'(tx_q.size() - n0), 32'd1);
      chk("er_tx0",    tx_at(n0), 32'h45);
      chk("er_line",   32'(uart_tx), 32'd1);
      cfg_err = 1'b0;

      // Truncated frame aborted by the gap timer, then a normal read
      n0 = tx_q.size(); g0 = grants; r0 = req_cycles;
      send_frame(72'h00_00_00_00_00_00_02_01_57, 3);
      chk("ab_busy_mid", 32'(busy_o), 32'd1);
      repeat (700) @(negedge clk);
      chk("ab_busy",   32'(busy_o), 32'd0);
      chk("ab_req",    32'(req_cycles - r0), 32'd0);
      chk("ab_grants", 32'(grants - g0), 32'd0);
      chk("ab_txn",    32'(tx_q.size() - n0), 32'd0);
      cfg_rdata = 32'hA5A5_0F0F;
      send_frame(72'h00_00_00_00_10_04_52, 5);
      wait_idle("ab_rd", 3000);
      chk("ab_rd_addr", g_addr, 32'h0000_1004);
      chk("ab_rd_txn",  32'(tx_q.size() - n0), 32'd4);
      chk("ab_rd_tx0",  tx_at(n0),     32'h0F);
      chk("ab_rd_tx3",  tx_at(n0 + 3), 32'hA5);

      // Junk leading byte, then a read that is never granted
      send_byte(8'h00);
      chk("junk_busy", 32'(busy_o), 32'd0);
      gnt_en = 1'b0;
      n0 = tx_q.size(); g0 = grants; r0 = req_cycles;
      send_frame(72'h00_00_00_00_00_08_52, 5);
      wait_idle("to", 5000);
      chk("to_req_cycles", 32'(req_cycles - r0), 32'd1024);
      chk("to_grants",     32'(grants - g0), 32'd0);
      chk("to_req",        32'(bus.req), 32'd0);
      chk("to_txn",        32'(tx_q.size() - n0), 32'd1);
      chk("to_tx0",        tx_at(n0), 32'h54);
      gnt_en = 1'b1;

      // Reset while waiting for rvalid
      rv_delay = 60;
      g0 = grants;
      send_frame(72'h00_00_00_00_01_00_52, 5);
      k = 0;
      while (grants == g0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("rw_grant", 32'(grants - g0), 32'd1);
      repeat (3) @(negedge clk);
      chk("rw_addr_pre", bus.addr, 32'h0000_0100);
      chk("rw_busy_pre", 32'(busy_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_req",  32'(bus.req), 32'd0);
      chk("rw_tx",   32'(uart_tx), 32'd1);
      chk("rw_busy", 32'(busy_o),  32'd0);
      chk("rw_addr", bus.addr,     32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rv_delay = 1;
      repeat (5) @(negedge clk);

      // Reset while a response byte is on the line
      send_frame(72'h00_00_00_00_00_00_00_00_57, 9);
      k = 0;
      while (uart_tx !== 1'b0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      chk("rt_start", 32'(uart_tx), 32'd0);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rt_tx",   32'(uart_tx), 32'd1);
      chk("rt_busy", 32'(busy_o),  32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rt_tx_after", 32'(uart_tx), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
